fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the cycle-accurate RISC-V core. Owns the program counter, drives the read port of the byte-addressed unified memory (combinational read, 32-bit little-endian word at any byte address), and registers each fetched instruction with its PC for the decode stage over a valid/ready handshake. Accepts redirects from execute and stops fetching at the end of the loaded program.

## Interface
- START_ADDR, 32'h01000000: reset PC; base of memory image
- MEM_SIZE, 1048576: memory size in bytes; legal PCs are START_ADDR .. START_ADDR+MEM_SIZE-4
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_addr  out  32  memory address; always equals pc
- imem_wen  out  1  memory write enable; constant 0
- imem_rdata  in  32  memory data_out, valid same cycle as imem_addr
- redirect_valid  in  1  execute requests PC change this cycle
- redirect_pc  in  32  redirect target
- if_valid  out  1  if_insn/if_pc hold an instruction for decode
- if_ready  in  1  decode accepts when if_valid && if_ready
- if_insn  out  32  registered instruction
- if_pc  out  32  address of if_insn
- done  out  1  fetch halted at end of program
- fault  out  1  fetch halted on illegal PC

## Operation
- FSM states: IDLE, RUN, DONE, FAULT.
- IDLE: entered on reset; one cycle, no fetch; next state RUN.
- RUN: "slot free" = !if_valid || if_ready. Slot free and no redirect: if imem_rdata != 0, load if_insn<=imem_rdata, if_pc<=pc, if_valid<=1, pc<=pc+4. If imem_rdata == 0 (zero-filled memory past program): if_valid<=0 once consumed, go DONE, pc holds.
- Slot not free and no redirect: pc, if_* hold; no fetch.
- Illegal pc (outside legal range): no fetch, if_valid<=0 once consumed, go FAULT.
- Redirect (any state except IDLE): pc<=redirect_pc, if_valid<=0 (flush, even if if_ready=1 same cycle; a handshake in that cycle still counts as accepted by decode), state<=RUN, done/fault clear. Redirect beats all other events.
- DONE/FAULT: pc, if_insn, if_pc hold; if_valid falls after pending handshake; exit only via redirect or reset.
- Arithmetic: pc+4 modulo 2^32; wrap past 32'hFFFFFFFC yields 0, which is illegal -> FAULT.

## Timing
- Reset values: pc=START_ADDR, if_valid=0, if_insn=0, if_pc=0, done=0, fault=0, state=IDLE; imem_addr=START_ADDR.
- First instruction presented on if_valid at the 2nd rising edge after rst_n deasserts.
- Throughput one instruction per cycle with if_ready held high; latency memory->if_insn one cycle.
- if_insn/if_pc stable while if_valid && !if_ready.
- First instruction after redirect appears one cycle after redirect edge (one bubble).
- done/fault registered; assert the edge the state enters DONE/FAULT.
- rst_n assertion mid-operation clears all state immediately, regardless of clk.

## Configuration
- FETCH_MISALIGN_EN defined: pc[1:0] != 0 is illegal; redirect to misaligned target enters FAULT on next edge with no fetch.
- Undefined: redirect_pc[1:0] forced to 0 on load; misalignment never faults.

## Structure
- fetch_pkg: START_ADDR/MEM_SIZE defaults, NOP and zero-instruction constants, fetch state enum type.
- Sub-module fetch_pc_reg: pc register, next-PC mux (reset/redirect/increment/hold), range and alignment checks; fetch_unit holds FSM and output register.

## Test plan
- Reset release, memory holds 0x00500093,0x00100113,0 from START_ADDR, if_ready=1 -> if_pc 0x01000000,0x01000004 on consecutive cycles, then done=1, if_valid=0, pc=0x01000008.
- if_ready low 3 cycles while if_valid -> if_insn/if_pc frozen, imem_addr constant, no PC advance; resumes at next address.
- redirect_valid with redirect_pc=0x01000100 while if_valid && if_ready -> next cycle if_valid=0, following cycle if_pc=0x01000100.
- redirect from DONE to 0x01000000 -> done clears, fetch restarts at program start.
- redirect_pc=0x00FFFFFC -> fault=1, if_valid=0, no further fetch until redirect.
- redirect_pc=0x01000002: with FETCH_MISALIGN_EN -> fault=1; without -> if_pc=0x01000000.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared constants and state type for the instruction fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  localparam logic [31:0] C_START_ADDR = 32'h0100_0000;
  localparam int unsigned C_MEM_SIZE   = 1048576;
  localparam logic [31:0] C_NOP_INSN   = 32'h0000_0013;
  localparam logic [31:0] C_ZERO_INSN  = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DONE  = 2'd2,
    S_FAULT = 2'd3
  } fetch_state_t;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_pc_reg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_reg
// Description : Program counter register, next-PC selection and legality check.
//               FETCH_MISALIGN_EN: misaligned PCs are illegal instead of masked.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] START_ADDR = C_START_ADDR,
  parameter int unsigned MEM_SIZE   = C_MEM_SIZE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        advance,
  output logic [31:0] pc,
  output logic        pc_legal
);

  localparam logic [31:0] C_PC_LAST = START_ADDR + 32'(MEM_SIZE) - 32'd4;

  logic [31:0] r_pc;
  logic [31:0] w_target;
  logic [31:0] w_pc_next;
  logic        w_aligned;

`ifdef FETCH_MISALIGN_EN
  assign w_target  = redirect_pc;
  assign w_aligned = (r_pc[1:0] == 2'b00);
`else
  // Target is word-aligned on load, so the PC can never become misaligned.
  assign w_target  = redirect_pc & ~32'h0000_0003;
  assign w_aligned = 1'b1;
`endif

  always_comb begin
    w_pc_next = r_pc;
    if (redirect)
      w_pc_next = w_target;
    else if (advance)
      w_pc_next = r_pc + 32'd4;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_pc <= START_ADDR;
    else
      r_pc <= w_pc_next;
  end

  assign pc       = r_pc;
  assign pc_legal = (r_pc >= START_ADDR) && (r_pc <= C_PC_LAST) && w_aligned;

endmodule : fetch_pc_reg
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage: FSM, instruction output register and
//               decode handshake. Optional macro: FETCH_MISALIGN_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] START_ADDR = C_START_ADDR,
  parameter int unsigned MEM_SIZE   = C_MEM_SIZE
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  output logic        imem_wen,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_insn,
  output logic [31:0] if_pc,
  output logic        done,
  output logic        fault
);

  fetch_state_t r_state;
  logic         r_if_valid;
  logic [31:0]  r_if_insn;
  logic [31:0]  r_if_pc;
  logic         r_done;
  logic         r_fault;

  logic [31:0]  w_pc;
  logic         w_pc_legal;
  logic         w_slot_free;
  logic         w_redirect;
  logic         w_fetch;

  assign w_slot_free = !r_if_valid || if_ready;
  assign w_redirect  = redirect_valid && (r_state != S_IDLE);
  assign w_fetch     = (r_state == S_RUN) && !w_redirect && w_pc_legal &&
                       w_slot_free && (imem_rdata != C_ZERO_INSN);

  fetch_pc_reg #(
    .START_ADDR (START_ADDR),
    .MEM_SIZE   (MEM_SIZE)
  ) u_pc_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .redirect    (w_redirect),
    .redirect_pc (redirect_pc),
    .advance     (w_fetch),
    .pc          (w_pc),
    .pc_legal    (w_pc_legal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_if_valid <= 1'b0;
      r_if_insn  <= 32'd0;
      r_if_pc    <= 32'd0;
      r_done     <= 1'b0;
      r_fault    <= 1'b0;
    end else if (w_redirect) begin
      // Flush wins even over a same-cycle handshake; decode still took that one.
      r_state    <= S_RUN;
      r_if_valid <= 1'b0;
      r_done     <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_RUN;
        S_RUN: begin
          if (!w_pc_legal) begin
            if (w_slot_free) r_if_valid <= 1'b0;
            r_fault <= 1'b1;
            r_state <= S_FAULT;
          end else if (w_slot_free) begin
            if (imem_rdata != C_ZERO_INSN) begin
              r_if_insn  <= imem_rdata;
              r_if_pc    <= w_pc;
              r_if_valid <= 1'b1;
            end else begin
              r_if_valid <= 1'b0;
              r_done     <= 1'b1;
              r_state    <= S_DONE;
            end
          end
        end
        S_DONE, S_FAULT: begin
          if (if_ready) r_if_valid <= 1'b0;
        end
      endcase
    end
  end

  assign imem_addr = w_pc;
  assign imem_wen  = 1'b0;
  assign if_valid  = r_if_valid;
  assign if_insn   = r_if_insn;
  assign if_pc     = r_if_pc;
  assign done      = r_done;
  assign fault     = r_fault;

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed self-checking bench for fetch_unit with a byte memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  localparam logic [31:0] C_START = 32'h0100_0000;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic        imem_wen;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_insn;
  logic [31:0] if_pc;
  logic        done;
  logic        fault;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  r_mem [0:1023];
  logic [31:0] w_off;

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_wen       (imem_wen),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_insn        (if_insn),
    .if_pc          (if_pc),
    .done           (done),
    .fault          (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 1 KiB image at C_START; everything else in the address space reads as zero.
  always_comb begin
    imem_rdata = 32'd0;
    w_off      = imem_addr - C_START;
    if (imem_addr >= C_START && w_off <= 32'd1020)
      imem_rdata = {r_mem[w_off[9:0] + 10'd3], r_mem[w_off[9:0] + 10'd2],
                    r_mem[w_off[9:0] + 10'd1], r_mem[w_off[9:0]]};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic put_word(input logic [31:0] addr, input logic [31:0] data);
    logic [9:0] o;
    o = 10'(addr - C_START);
    r_mem[o]         = data[7:0];
    r_mem[o + 10'd1] = data[15:8];
    r_mem[o + 10'd2] = data[23:16];
    r_mem[o + 10'd3] = data[31:24];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect_to(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) r_mem[i] = 8'h00;
    put_word(32'h0100_0000, 32'h0050_0093);
    put_word(32'h0100_0004, 32'h0010_0113);
    put_word(32'h0100_0040, 32'h0000_0013);
    put_word(32'h0100_0044, 32'h0020_8133);
    put_word(32'h0100_0048, 32'h4000_0193);
    put_word(32'h0100_004C, 32'h00C0_0213);
    put_word(32'h0100_0100, 32'h00A0_0293);

    rst_n          = 1'b0;
    if_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    #12;
    chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_if_insn", if_insn, 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_addr", imem_addr, C_START);
    chk("rst_wen", {31'd0, imem_wen}, 32'd0);

    // Program run from reset
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_no_fetch", {31'd0, if_valid}, 32'd0);
    tick();
    chk("i0_valid", {31'd0, if_valid}, 32'd1);
    chk("i0_pc", if_pc, 32'h0100_0000);
    chk("i0_insn", if_insn, 32'h0050_0093);
    tick();
    chk("i1_pc", if_pc, 32'h0100_0004);
    chk("i1_insn", if_insn, 32'h0010_0113);
    tick();
    chk("end_done", {31'd0, done}, 32'd1);
    chk("end_valid", {31'd0, if_valid}, 32'd0);
    chk("end_pc", imem_addr, 32'h0100_0008);
    tick();
    chk("end_pc_hold", imem_addr, 32'h0100_0008);

    // Backpressure
    redirect_to(32'h0100_0040);
    chk("rd40_done_clr", {31'd0, done}, 32'd0);
    chk("rd40_bubble", {31'd0, if_valid}, 32'd0);
    chk("rd40_addr", imem_addr, 32'h0100_0040);
    tick();
    chk("s0_pc", if_pc, 32'h0100_0040);
    if_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_valid", {31'd0, if_valid}, 32'd1);
      chk("stall_pc", if_pc, 32'h0100_0040);
      chk("stall_insn", if_insn, 32'h0000_0013);
      chk("stall_addr", imem_addr, 32'h0100_0044);
    end
    if_ready = 1'b1;
    tick();
    chk("resume_pc", if_pc, 32'h0100_0044);
    chk("resume_insn", if_insn, 32'h0020_8133);
    chk("resume_addr", imem_addr, 32'h0100_0048);

    // Redirect during a handshake flushes
    redirect_to(32'h0100_0100);
    chk("flush_valid", {31'd0, if_valid}, 32'd0);
    tick();
    chk("rd100_valid", {31'd0, if_valid}, 32'd1);
    chk("rd100_pc", if_pc, 32'h0100_0100);
    chk("rd100_insn", if_insn, 32'h00A0_0293);
    tick();
    chk("rd100_done", {31'd0, done}, 32'd1);

    // Restart from DONE
    redirect_to(32'h0100_0000);
    chk("restart_done", {31'd0, done}, 32'd0);
    tick();
    chk("restart_pc", if_pc, 32'h0100_0000);
    chk("restart_insn", if_insn, 32'h0050_0093);

    // Below legal range
    redirect_to(32'h00FF_FFFC);
    chk("low_valid", {31'd0, if_valid}, 32'd0);
    tick();
    chk("low_fault", {31'd0, fault}, 32'd1);
    chk("low_done", {31'd0, done}, 32'd0);
    chk("low_valid2", {31'd0, if_valid}, 32'd0);
    tick();
    chk("low_addr_hold", imem_addr, 32'h00FF_FFFC);
    chk("low_fault_hold", {31'd0, fault}, 32'd1);

    // Last legal word reads zero -> DONE, one past -> FAULT
    redirect_to(32'h010F_FFFC);
    chk("top_fault_clr", {31'd0, fault}, 32'd0);
    tick();
    chk("top_done", {31'd0, done}, 32'd1);
    chk("top_fault", {31'd0, fault}, 32'd0);
    redirect_to(32'h0110_0000);
    tick();
    chk("over_fault", {31'd0, fault}, 32'd1);

    // Misaligned redirect
    redirect_to(32'h0100_0002);
`ifdef FETCH_MISALIGN_EN
    chk("mis_bubble", {31'd0, if_valid}, 32'd0);
    tick();
    chk("mis_fault", {31'd0, fault}, 32'd1);
    chk("mis_valid", {31'd0, if_valid}, 32'd0);
`else
    chk("mis_addr", imem_addr, 32'h0100_0000);
    tick();
    chk("mis_pc", if_pc, 32'h0100_0000);
    chk("mis_fault", {31'd0, fault}, 32'd0);
`endif

    // Asynchronous reset between clock edges
    rst_n = 1'b0;
    #2;
    chk("arst_valid", {31'd0, if_valid}, 32'd0);
    chk("arst_fault", {31'd0, fault}, 32'd0);
    chk("arst_addr", imem_addr, C_START);
    chk("arst_pc", if_pc, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_fetch_unit
`default_nettype wire
